// File: rtl/cfg_loader.sv
// cfg_loader: serial configuration transmitter for an S3GA cluster.
// Gearboxes host words into CFG_W-bit beats, then awaits cfgd.
module cfg_loader #(
  parameter int WORD_W    = 32,
  parameter int CFG_W     = 5,
  parameter int CFG_BEATS = 1024,
  parameter int TIMEOUT   = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              w_valid,
  output logic              w_ready,
  input  logic [WORD_W-1:0] w_data,
  output logic              cfg,
  output logic [CFG_W-1:0]  cfg_o,
  output logic              grst,
  input  logic              cfgd,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int BUF_W = WORD_W + CFG_W - 1;
  localparam int CNT_W = $clog2(BUF_W + 1);
  localparam int REM_W = $clog2(CFG_BEATS + 1);
  localparam int TMR_W = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_WAIT,
    S_DONE,
    S_ERR
  } state_t;

  state_t           state_q, state_d;
  logic [BUF_W-1:0] sbuf_q, sbuf_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [REM_W-1:0] rem_q, rem_d;
  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic             cfg_d;
  logic [CFG_W-1:0] cfg_o_d;
  logic             grst_d;
  logic             done_d;
  logic             err_d;

  logic             emit;
  logic             acc;
  logic [BUF_W-1:0] shifted;
  logic [CNT_W-1:0] base;

  // A beat leaves whenever a full beat sits in the buffer.
  assign emit    = (state_q == S_LOAD) && (cnt_q >= CNT_W'(CFG_W));
  assign acc     = w_valid && w_ready;
  assign shifted = emit ? (sbuf_q >> CFG_W) : sbuf_q;
  assign base    = emit ? (cnt_q - CNT_W'(CFG_W)) : cnt_q;

  // State register plus registered datapath and outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      sbuf_q  <= '0;
      cnt_q   <= '0;
      rem_q   <= '0;
      tmr_q   <= '0;
      cfg     <= 1'b0;
      cfg_o   <= '0;
      grst    <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
    end else begin
      state_q <= state_d;
      sbuf_q  <= sbuf_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      tmr_q   <= tmr_d;
      cfg     <= cfg_d;
      cfg_o   <= cfg_o_d;
      grst    <= grst_d;
      done    <= done_d;
      err     <= err_d;
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_d = state_q;
    sbuf_d  = sbuf_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    tmr_d   = tmr_q;
    cfg_d   = 1'b0;
    cfg_o_d = '0;
    grst_d  = grst;
    done_d  = done;
    err_d   = err;
    unique case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          state_d = S_LOAD;
          sbuf_d  = '0;
          cnt_d   = '0;
          rem_d   = REM_W'(CFG_BEATS);
          grst_d  = 1'b1;
          done_d  = 1'b0;
          err_d   = 1'b0;
        end
      end
      S_LOAD: begin
        sbuf_d = acc ? (shifted | (BUF_W'(w_data) << base)) : shifted;
        cnt_d  = acc ? (base + CNT_W'(WORD_W)) : base;
        if (emit) begin
          cfg_d   = 1'b1;
          cfg_o_d = sbuf_q[CFG_W-1:0];
          rem_d   = rem_q - REM_W'(1);
          if (rem_q == REM_W'(1)) begin
            state_d = S_WAIT;
            tmr_d   = '0;
          end
        end
      end
      S_WAIT: begin
        if (cfgd) begin
          state_d = S_DONE;
          grst_d  = 1'b0;
          done_d  = 1'b1;
        end else if (tmr_q == TMR_W'(TIMEOUT - 1)) begin
          state_d = S_ERR;
          grst_d  = 1'b0;
          err_d   = 1'b1;
        end else begin
          tmr_d = tmr_q + TMR_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Handshake and status outputs decoded from the current state.
  always_comb begin
    busy    = (state_q == S_LOAD) || (state_q == S_WAIT);
    w_ready = 1'b0;
    if (state_q == S_LOAD) begin
      w_ready = (32'(cnt_q) + 32'(WORD_W) <= 32'(BUF_W))
             && (32'(rem_q) * 32'(CFG_W) > 32'(cnt_q));
    end
  end

endmodule

// File: doc/cfg_loader.md
Name: cfg_loader

Overview:
- Configuration transmitter that drives the serial configuration port of an S3GA cluster: it produces `cfg`/`cfg_i`, asserts `grst`, and consumes `cfgd`.
- Accepts bitstream words from a host or boot ROM over a valid/ready interface.
- Gearboxes each WORD_W-bit word into CFG_W-bit beats, emits exactly CFG_BEATS beats, then waits for the cluster to report configured.
- Sits between the SoC/bootstrap logic and the top cluster's config input.

Parameters:
WORD_W, 32, host word width in bits; must be >= CFG_W.
CFG_W, 5, config beat width; must match the cluster's CFG_W.
CFG_BEATS, 1024, total beats per configuration; must be >= 1.
TIMEOUT, 255, maximum cycles in WAIT_CFGD before error; must be >= 1.

Ports:
clk  input  1  clock
rst  input  1  asynchronous reset, active-low (0 = reset)
start  input  1  one-cycle pulse; begins a load when in IDLE, DONE or ERR
w_valid  input  1  host word valid
w_ready  output  1  word accepted when w_valid & w_ready at a rising edge
w_data  input  WORD_W  bitstream word, LSB first
cfg  output  1  config beat strobe (to cluster `cfg`)
cfg_o  output  CFG_W  config beat data (to cluster `cfg_i`)
grst  output  1  configuration in progress (to cluster `grst`)
cfgd  input  1  cluster reports configured
busy  output  1  state is LOAD or WAIT_CFGD
done  output  1  configuration succeeded; sticky
err  output  1  cfgd timeout; sticky

Behaviour:
- Reset (rst=0, asynchronous):
  - State IDLE.
  - buf, cnt, beat counter and timer cleared.
  - All outputs 0, including w_ready.
- Internal state:
  - buf: BUF_W = WORD_W+CFG_W-1 bits.
  - cnt: number of valid bits in buf, 0..BUF_W.
  - rem: beats remaining.
  - Shift buffer and counters are registered; cfg, cfg_o, grst, done and err are registered outputs.
- IDLE/DONE/ERR, start=1:
  - Next state LOAD; rem<=CFG_BEATS, cnt<=0.
  - grst<=1; done<=0, err<=0.
- start is ignored in LOAD and WAIT_CFGD.
- w_ready (combinational) = state==LOAD && cnt+WORD_W<=BUF_W && rem*CFG_W > cnt.
  - The block never requests bits beyond those needed for the remaining beats.
  - w_ready is 0 outside LOAD.
- Emit (LOAD, cnt>=CFG_W at the edge):
  - cfg<=1, cfg_o<=buf[CFG_W-1:0].
  - buf shifts right by CFG_W; cnt-=CFG_W; rem-=1.
  - Otherwise cfg<=0 and cfg_o<=0 (cfg_o is zero whenever cfg=0).
- Accept at the same edge as an emit:
  - The new word is written at bit position cnt-CFG_W of the post-shift buf; cnt = cnt-CFG_W+WORD_W.
- Accept with no emit:
  - The word is written at position cnt; cnt+=WORD_W.
- Latency: a word accepted at edge t with cnt=0 produces its first beat with cfg=1 during the cycle after edge t+1. Steady throughput is 1 beat/cycle while bits are available.
- The host may stall freely; gaps produce cfg=0 cycles. Beat order and content are unaffected.
- Leftover bits of the final word beyond CFG_BEATS*CFG_W total are discarded.
- Last beat emitted (rem 1->0):
  - Next state WAIT_CFGD; timer<=0; grst stays 1.
- WAIT_CFGD:
  - cfgd=1: DONE, grst<=0, done<=1.
  - Otherwise timer+=1; timer==TIMEOUT-1 with cfgd=0: ERR, grst<=0, err<=1.
  - A cfgd seen at the same edge as the timeout wins; the result is DONE.
- cfgd is ignored in all states except WAIT_CFGD.
- done and err are held until the next start or reset.
- Reset mid-LOAD: outputs drop immediately and the partial buffer is lost. A subsequent start reloads from beat 0.

Test Plan:
- Basic load:
  - Stimulus: WORD_W=10, CFG_W=5, CFG_BEATS=4; start; words 0x041, 0x083 back-to-back.
  - Required: cfg=1 for exactly 4 cycles with cfg_o 1,2,3,4; grst=1 from the cycle after start until done; cfgd=1 two cycles after the last beat -> done=1, grst=0, busy=0.
- Gearbox remainder:
  - Stimulus: WORD_W=32, CFG_W=5, CFG_BEATS=13; words 0xFFFFFFFF, 0x00000000, 0x00000000 with random valid gaps.
  - Required: w_ready drops after word 3 (65 bits ≥ 13×5); beats 1-6 = 0x1F, beat 7 = 0x03, beats 8-13 = 0; no 4th word accepted.
- Backpressure:
  - Stimulus: w_valid held high continuously.
  - Required: w_ready is never 1 while cnt+WORD_W>BUF_W; no beat is lost or duplicated (scoreboard compares the beat stream against the word stream).
- Timeout:
  - Stimulus: TIMEOUT=8; cfgd held 0 after the last beat.
  - Required: err=1, grst=0 exactly 8 cycles after entering WAIT_CFGD; a later start clears err and reloads.
- Timeout race and ignored start:
  - Stimulus: cfgd rises on the timeout edge; separately, start pulsed mid-LOAD.
  - Required: done=1, err=0 for the race; the mid-LOAD start has no effect on rem or the beat stream.
- Async reset mid-load:
  - Stimulus: rst=0 asserted between clock edges after beat 2, then released; start; full word stream.
  - Required: cfg, grst, busy and w_ready go 0 without waiting for a clock edge; the restarted load emits all CFG_BEATS beats from beat 0.
